// File: rtl/uart_peripheral.sv
// UART peripheral: bus register file, TX FIFO with transmitter, synchronised receiver.
`timescale 1ns/1ps
module uart_peripheral #(
  parameter int unsigned CLKS_PER_BIT = 625,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic [31:0] data_in,
  input  logic [3:0]  write_mask,
  output logic [31:0] data_out,
  input  logic        bus_enable,
  input  logic        write_enable,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FCNT_W-1:0] FIFO_CAP  = FCNT_W'(FIFO_DEPTH);
  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_RX     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus decode; side effects only on the first cycle of an access
  logic       bus_en_q;
  logic [1:0] reg_sel;
  logic       access_first, push_req, w1c, rx_clear;
  assign reg_sel      = address[3:2];
  assign access_first = bus_enable & ~bus_en_q;
  assign push_req     = access_first & write_enable & (reg_sel == REG_TX) & ~write_mask[0];
  assign w1c          = access_first & write_enable & (reg_sel == REG_STATUS) & ~write_mask[0];
  assign rx_clear     = access_first & ~write_enable & (reg_sel == REG_RX);

  logic unused_bits;
  assign unused_bits = ^{address[1:0], data_in[31:8], write_mask[3:1]};

  // TX FIFO state
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty, push_ok, tx_pop, tx_overflow;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_clk_cnt;
  logic [2:0]       tx_bit_cnt;
  logic [7:0]       tx_shift;
  logic             tx_busy;

  assign fifo_full  = (fifo_count == FIFO_CAP);
  assign fifo_empty = (fifo_count == '0);
  assign push_ok    = push_req & ~fifo_full;
  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx_pop     = ~fifo_empty & ((tx_state == TX_IDLE) ||
                      ((tx_state == TX_STOP) && (tx_clk_cnt == BIT_LAST)));

  // Bus request edge tracker
  always_ff @(posedge clk) begin
    if (reset) bus_en_q <= 1'b0;
    else       bus_en_q <= bus_enable;
  end

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= data_in[7:0];
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, tx_pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (w1c && data_in[5])     tx_overflow <= 1'b0;
      if (push_req && fifo_full) tx_overflow <= 1'b1;
    end
  end

  // Transmit FSM: start, 8 data bits LSB first, stop; back-to-back frames when queued
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      tx         <= 1'b1;
      tx_clk_cnt <= '0;
      tx_bit_cnt <= '0;
      tx_shift   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_pop) begin
            tx_state   <= TX_START;
            tx         <= 1'b0;
            tx_shift   <= fifo_mem[rd_ptr];
            tx_clk_cnt <= '0;
          end
        end
        TX_START: begin
          if (tx_clk_cnt == BIT_LAST) begin
            tx_clk_cnt <= '0;
            tx_bit_cnt <= '0;
            tx_state   <= TX_DATA;
            tx         <= tx_shift[0];
            tx_shift   <= {1'b0, tx_shift[7:1]};
          end else begin
            tx_clk_cnt <= tx_clk_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_clk_cnt == BIT_LAST) begin
            tx_clk_cnt <= '0;
            if (tx_bit_cnt == 3'd7) begin
              tx_state <= TX_STOP;
              tx       <= 1'b1;
            end else begin
              tx_bit_cnt <= tx_bit_cnt + 3'd1;
              tx         <= tx_shift[0];
              tx_shift   <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_clk_cnt <= tx_clk_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_clk_cnt == BIT_LAST) begin
            tx_clk_cnt <= '0;
            if (tx_pop) begin
              tx_state <= TX_START;
              tx       <= 1'b0;
              tx_shift <= fifo_mem[rd_ptr];
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_clk_cnt <= tx_clk_cnt + CNT_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receiver state
  logic             rx_meta, rx_sync, rx_sync_q, rx_fall;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_clk_cnt;
  logic [2:0]       rx_bit_cnt;
  logic [7:0]       rx_shift, rx_byte;
  logic             rx_valid, rx_overrun, rx_frame_err;

  assign rx_fall = rx_sync_q & ~rx_sync;

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_sync_q <= rx_sync;
    end
  end

  // Receive FSM with glitch rejection, mid-bit sampling and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      rx_clk_cnt   <= '0;
      rx_bit_cnt   <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_clear)           rx_valid     <= 1'b0;
      if (w1c && data_in[4])  rx_overrun   <= 1'b0;
      if (w1c && data_in[6])  rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state   <= RX_START;
            rx_clk_cnt <= '0;
          end
        end
        RX_START: begin
          if (rx_clk_cnt == HALF_LAST) begin
            rx_clk_cnt <= '0;
            rx_bit_cnt <= '0;
            rx_state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_clk_cnt == BIT_LAST) begin
            rx_clk_cnt <= '0;
            rx_shift   <= {rx_sync, rx_shift[7:1]};
            if (rx_bit_cnt == 3'd7) rx_state <= RX_STOP;
            else                    rx_bit_cnt <= rx_bit_cnt + 3'd1;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_clk_cnt == BIT_LAST) begin
            rx_clk_cnt <= '0;
            rx_state   <= RX_IDLE;
            if (rx_sync) begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_clear) rx_overrun <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            rx_clk_cnt <= rx_clk_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [31:0] status_word;
  assign status_word = {25'b0, rx_frame_err, tx_overflow, rx_overrun, rx_valid,
                        fifo_empty, fifo_full, tx_busy};

  // Registered read data; holds when no read is requested
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (bus_enable && !write_enable) begin
      case (reg_sel)
        REG_RX:     data_out <= {24'b0, rx_byte};
        REG_STATUS: data_out <= status_word;
        default:    data_out <= '0;
      endcase
    end
  end

endmodule

// File: doc/uart_peripheral.md
UART_PERIPHERAL -- requirements
Module: uart_peripheral

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 625, clk cycles per UART bit (9600 baud at 6 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries (power of two).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 address  input  4  byte address within block; [3:2] selects register, [1:0] ignored.
REQ-006 data_in  input  32  write data from bus initiator.
REQ-007 write_mask  input  4  active-low byte-lane enables; 0 = lane written.
REQ-008 data_out  output  32  registered read data.
REQ-009 bus_enable  input  1  access request.
REQ-010 write_enable  input  1  1 = write, 0 = read (qualified by bus_enable).
REQ-011 tx  output  1  UART transmit line, idle high.
REQ-012 rx  input  1  UART receive line, asynchronous.

Function
REQ-013 Register map: 0x0 TX_DATA (W), 0x4 RX_DATA (R), 0x8 STATUS (R/W1C), 0xC reserved (reads 0, writes ignored).
REQ-014 Read: on each edge with bus_enable=1, write_enable=0, data_out SHALL load selected register; otherwise data_out holds; read data valid one cycle after request.
REQ-015 Side effects (FIFO push, RX clear, W1C) SHALL occur only on the first cycle of an access (bus_enable high, previous-cycle bus_enable low).
REQ-016 TX_DATA write with write_mask[0]=0 SHALL push data_in[7:0]; TX_DATA reads return 0.
REQ-017 Push while FIFO full (pre-cycle count = FIFO_DEPTH) SHALL be dropped and set tx_overflow, even if a pop occurs in the same cycle.
REQ-018 RX_DATA read SHALL return {24'b0, rx_byte} and clear rx_valid.
REQ-019 STATUS bits: [0] tx_busy, [1] tx_full, [2] tx_empty, [3] rx_valid, [4] rx_overrun, [5] tx_overflow, [6] rx_frame_err, [31:7] 0.
REQ-020 STATUS write with write_mask[0]=0 SHALL clear bits 4-6 where data_in bit is 1; other bits unaffected.
REQ-021 TX FSM states IDLE, START, DATA, STOP; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-022 IDLE -> START when FIFO non-empty; entry to START pops FIFO head into shift register; tx=0.
REQ-023 DATA sends 8 bits LSB first; STOP drives tx=1 one bit time.
REQ-024 End of STOP -> START directly if FIFO non-empty (no idle gap), else IDLE.
REQ-025 tx_busy = 1 in any state except IDLE.
REQ-026 rx SHALL pass a 2-flop synchronizer before use.
REQ-027 RX FSM states IDLE, START, DATA, STOP; falling edge in IDLE -> START; start rechecked at half bit; if high, return to IDLE (glitch).
REQ-028 Data bits sampled at bit centres, LSB first.
REQ-029 Stop sample 1: rx_byte loaded, rx_valid set; if rx_valid already 1, set rx_overrun and overwrite rx_byte.
REQ-030 Stop sample 0: byte discarded, rx_frame_err set, rx_valid unchanged.
REQ-031 RX_DATA read coinciding with byte completion: new byte wins, rx_valid stays 1, rx_overrun not set.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-033 On reset: tx=1, data_out=0, FIFO empty, rx_byte=0, all STATUS flags 0 except tx_empty=1, both FSMs IDLE, bit counters 0.
REQ-034 Reset mid-frame SHALL abort TX/RX immediately; tx=1 next cycle; queued bytes lost.

Verification (CLKS_PER_BIT=4)
REQ-035 Write 0x0 data 0x000000A5 mask 0000 -> tx: start low 4 cycles, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4; total 40 cycles.
REQ-036 Five TX_DATA writes 0x11..0x15 back-to-back while idle -> first pops immediately, remaining four fill FIFO, 0x15 accepted; sixth write 0x16 -> dropped, STATUS bit5=1; frames 0x11..0x15 with no idle gap.
REQ-037 Drive rx frame 0x3C -> STATUS reads 0x0000000C (tx_empty, rx_valid); RX_DATA read -> 0x0000003C; next STATUS read -> 0x00000004.
REQ-038 Two rx frames 0x01, 0x02 without read -> RX_DATA=0x02, STATUS bit4=1; STATUS write 0x10 mask 1110 -> bit4=0.
REQ-039 rx frame with stop bit 0 -> rx_valid=0, STATUS bit6=1; 1-cycle low glitch on idle rx -> no flag change.
REQ-040 Assert reset during DATA of TX frame -> tx=1 next cycle, STATUS=0x00000004, no further frame output.
